// File: rtl/irrigation_zone_scheduler.sv
// Irrigation zone scheduler: grants one zone at a time a shared duration counter and drives its valve.
// Build option: define SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module irrigation_zone_scheduler #(
  parameter int unsigned NZONES = 4,
  parameter int unsigned CW     = 4,
  parameter int unsigned GAP    = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NZONES-1:0]         REQ,
  input  logic [NZONES*CW-1:0]      DUR,
  input  logic                      TICK,
  input  logic                      PAUSE,
  output logic [NZONES-1:0]         VALVE,
  output logic                      BUSY,
  output logic [$clog2(NZONES)-1:0] ZONE,
  output logic [CW-1:0]             REMAIN,
  output logic                      DONE
);

  localparam int unsigned ZW = $clog2(NZONES);
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP
  } state_t;

  state_t        state, state_n;
  logic [ZW-1:0] zone_n;
  logic [CW-1:0] remain_n;
  logic          done_n;
  logic          busy_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic          grant_vld;
  logic [ZW-1:0] grant_idx;
  logic [CW-1:0] dur_sel;
  logic          run_step;

`ifndef SCHED_FIXED_PRIO_EN
  logic [ZW-1:0] last, last_n;
`endif

  assign dur_sel  = DUR[int'(ZONE) * int'(CW) +: CW];
  assign run_step = TICK && !PAUSE;

  // Grant search; scanned from lowest to highest priority so the winner is written last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
`ifdef SCHED_FIXED_PRIO_EN
    for (int i = int'(NZONES) - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        grant_vld = 1'b1;
        grant_idx = ZW'(i);
      end
    end
`else
    for (int k = int'(NZONES); k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % int'(NZONES);
      if (REQ[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ZW'(idx);
      end
    end
`endif
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_n   = state;
    zone_n    = ZONE;
    remain_n  = REMAIN;
    done_n    = 1'b0;
    gap_cnt_n = gap_cnt;
`ifndef SCHED_FIXED_PRIO_EN
    last_n    = last;
`endif
    case (state)
      S_IDLE: begin
        if (!PAUSE && grant_vld) begin
          zone_n  = grant_idx;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        remain_n  = dur_sel;
        gap_cnt_n = GW'(GAP - 1);
        if (dur_sel == '0) begin
          state_n = S_GAP;
`ifndef SCHED_FIXED_PRIO_EN
          last_n  = ZONE;
`endif
        end else begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        // The <= 1 test keeps REMAIN from ever wrapping below zero.
        if (run_step) begin
          if (REMAIN <= CW'(1)) begin
            remain_n = '0;
            done_n   = 1'b1;
            state_n  = S_GAP;
`ifndef SCHED_FIXED_PRIO_EN
            last_n   = ZONE;
`endif
          end else begin
            remain_n = REMAIN - CW'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - GW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      ZONE    <= '0;
      REMAIN  <= '0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
      gap_cnt <= '0;
`ifndef SCHED_FIXED_PRIO_EN
      last    <= ZW'(NZONES - 1);
`endif
    end else begin
      state   <= state_n;
      ZONE    <= zone_n;
      REMAIN  <= remain_n;
      DONE    <= done_n;
      BUSY    <= busy_n;
      gap_cnt <= gap_cnt_n;
`ifndef SCHED_FIXED_PRIO_EN
      last    <= last_n;
`endif
    end
  end

  // Valve decoded from registered state so PAUSE shuts it within the same cycle.
  always_comb begin
    VALVE = '0;
    if (state == S_RUN && !PAUSE) begin
      VALVE[ZONE] = 1'b1;
    end
  end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Randomized scoreboard bench for irrigation_zone_scheduler against an interval-level reference model.
module tb_irrigation_zone_scheduler;

  localparam int NZONES = 4;
  localparam int CW     = 4;
  localparam int GAP    = 2;
  localparam int MAXL   = 100;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  REQ = '0;
  logic [15:0] DUR = '0;
  logic        TICK = 1'b0;
  logic        PAUSE = 1'b0;
  logic [3:0]  VALVE;
  logic        BUSY;
  logic [1:0]  ZONE;
  logic [3:0]  REMAIN;
  logic        DONE;

  irrigation_zone_scheduler #(.NZONES(NZONES), .CW(CW), .GAP(GAP)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .DUR(DUR), .TICK(TICK), .PAUSE(PAUSE),
    .VALVE(VALVE), .BUSY(BUSY), .ZONE(ZONE), .REMAIN(REMAIN), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        s_rst[MAXL];
  logic [3:0]  s_req[MAXL];
  logic [15:0] s_dur[MAXL];
  logic        s_tick[MAXL];
  logic        s_pause[MAXL];

  logic [3:0]  e_valve[MAXL];
  logic        e_busy[MAXL];
  logic [1:0]  e_zone[MAXL];
  logic [3:0]  e_remain[MAXL];

  typedef struct {
    int zone;
    int cyc;
  } done_t;
  done_t sbq[$];

  int seg_len = 0;
  int seg_base = 0;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic int pick(logic [3:0] rq, int last);
`ifdef SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NZONES; i++) if (rq[i]) return i;
`else
    for (int k = 1; k <= NZONES; k++) if (rq[(last + k) % NZONES]) return (last + k) % NZONES;
`endif
    return 0;
  endfunction

  task automatic mark(int c, logic [3:0] v, logic b, int z, int r);
    if (c < seg_len) begin
      e_valve[c]  = v;
      e_busy[c]   = b;
      e_zone[c]   = 2'(z);
      e_remain[c] = 4'(r);
    end
  endtask

  // Walk the segment run by run: idle -> one load cycle -> ticks consumed -> GAP closed cycles.
  task automatic run_model();
    int c, g, last, zone, rem, d;
    done_t r;
    last = NZONES - 1;
    zone = 0;
    for (int i = 0; i < seg_len; i++) mark(i, 4'b0, 1'b0, 0, 0);
    c = 1;
    while (c < seg_len) begin
      mark(c, 4'b0, 1'b0, zone, 0);
      if (!s_pause[c] && s_req[c] != 4'b0) begin
        g = pick(s_req[c], last);
        zone = g;
        c++;
        if (c >= seg_len) break;
        mark(c, 4'b0, 1'b1, zone, 0);
        d = int'((s_dur[c] >> (4 * g)) & 16'hF);
        c++;
        if (d != 0) begin
          rem = d;
          while (rem != 0 && c < seg_len) begin
            mark(c, s_pause[c] ? 4'b0 : 4'(1 << g), 1'b1, zone, rem);
            if (s_tick[c] && !s_pause[c]) rem--;
            c++;
          end
          if (rem == 0) begin
            r.zone = g;
            r.cyc  = seg_base + c;
            sbq.push_back(r);
          end
        end
        last = g;
        for (int k = 0; k < GAP; k++) begin
          mark(c, 4'b0, 1'b1, zone, 0);
          c++;
        end
      end else begin
        c++;
      end
    end
  endtask

  task automatic gen(int mode);
    logic [3:0]  rq;
    logic [15:0] du;
    du = 16'($urandom);
    rq = 4'($urandom);
    case (mode)
      0: begin seg_len = 30; du[3:0] = 4'd3; end
      1: begin seg_len = 40; du = 16'h1111; end
      2: begin seg_len = 45; du[11:8] = 4'd5; end
      3: begin seg_len = 40; du[7:4] = 4'd0; du[15:12] = 4'd2; du[11:8] = 4'd2; du[3:0] = 4'd2; end
      4: begin seg_len = 6; du[3:0] = 4'd7; end
      5: seg_len = 40;
      7: seg_len = 4;
      default: seg_len = $urandom_range(20, 80);
    endcase
    for (int c = 0; c < seg_len; c++) begin
      s_rst[c] = (c == 0);
      s_pause[c] = 1'b0;
      s_dur[c] = du;
      case (mode)
        0: begin s_req[c] = 4'b0001; s_tick[c] = (c % 4 == 3); end
        1: begin s_req[c] = 4'b1111; s_tick[c] = 1'($urandom); end
        2: begin s_req[c] = 4'b0100; s_tick[c] = (c % 2 == 1); s_pause[c] = (c >= 3 && c < 13); end
        3: begin s_req[c] = (c < 8) ? 4'b0010 : 4'b1111; s_tick[c] = 1'($urandom); end
        4: begin s_req[c] = 4'b0001; s_tick[c] = 1'b0; end
        5: begin s_req[c] = 4'b1001; s_tick[c] = 1'($urandom); end
        7: begin s_req[c] = 4'b0000; s_tick[c] = 1'b0; end
        default: begin
          if ($urandom % 6 == 0) rq = 4'($urandom);
          if ($urandom % 16 == 0) du = 16'($urandom);
          s_req[c] = rq;
          s_dur[c] = du;
          s_tick[c] = ($urandom % 3 == 0);
          s_pause[c] = ($urandom % 8 == 0);
        end
      endcase
    end
  endtask

  task automatic run_segment(int mode);
    gen(mode);
    for (int c = 0; c < seg_len; c++) begin
      @(posedge CLK);
      #1;
      if (c == 0) begin
        seg_base = cyc;
        run_model();
      end
      RESET = s_rst[c];
      REQ   = s_req[c];
      DUR   = s_dur[c];
      TICK  = s_tick[c];
      PAUSE = s_pause[c];
      @(negedge CLK);
      if (c == 1) chk("reset_done", int'(DONE), 0);
      if (c >= 1) begin
        chk("valve", int'(VALVE), int'(e_valve[c]));
        chk("busy", int'(BUSY), int'(e_busy[c]));
        chk("zone", int'(ZONE), int'(e_zone[c]));
        chk("remain", int'(REMAIN), int'(e_remain[c]));
      end
    end
  endtask

  // Monitor: every DONE pulse must match the oldest predicted run completion.
  always @(negedge CLK) begin
    if (DONE) begin
      done_t r;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done cyc=%0d zone=%0d", cyc, ZONE);
      end else begin
        r = sbq.pop_front();
        if (r.zone != int'(ZONE) || r.cyc != cyc) begin
          failures++;
          $display("FAIL done_event got zone=%0d cyc=%0d exp zone=%0d cyc=%0d", ZONE, cyc, r.zone, r.cyc);
        end
      end
    end
  end

  initial begin
    run_segment(0);
    run_segment(1);
    run_segment(2);
    run_segment(3);
    run_segment(4);
    run_segment(1);
    run_segment(5);
    for (int i = 0; i < 30; i++) run_segment(6);
    run_segment(7);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irrigation_zone_scheduler.md
Name: irrigation_zone_scheduler

Overview:
Sequences a shared 4-bit duration counter across several irrigation zones.
- Arbitrates among zone watering requests, round-robin by default.
- Loads the granted zone's duration, counts it down on timebase ticks and drives that zone's valve.
- Enforces a valve-settling gap between zones.
- Sits between the moisture-sensing front end and the valve drivers in the irrigation top level.

Parameters:
- NZONES, 4, number of zones/requesters (2..8).
- CW, 4, duration counter width in ticks.
- GAP, 2, idle clock cycles with all valves closed between consecutive zone runs (>=1).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NZONES  per-zone watering request, level.
- DUR  in  NZONES*CW  per-zone duration in ticks; zone i at bits [i*CW +: CW].
- TICK  in  1  one-cycle timebase strobe.
- PAUSE  in  1  rain/pressure inhibit, level.
- VALVE  out  NZONES  one-hot valve drive.
- BUSY  out  1  high from LOAD through GAP.
- ZONE  out  clog2(NZONES)  index of granted zone.
- REMAIN  out  CW  ticks remaining.
- DONE  out  1  one-cycle pulse when a zone run completes.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Forces state IDLE, VALVE=0, BUSY=0, ZONE=0, REMAIN=0, DONE=0.
  - Last-served pointer = NZONES-1, so the first search starts at zone 0.
  - RESET asserted mid-run closes the valve on the next edge; the run is lost and no DONE is issued.
- State IDLE:
  - If PAUSE=1, stay in IDLE.
  - If PAUSE=0 and |REQ: grant the first requester searching upward from last+1 with wrap, latch ZONE, go to LOAD.
- State LOAD, one cycle:
  - BUSY=1. REMAIN <= DUR[ZONE].
  - If DUR[ZONE]==0: zone skipped, last <= ZONE, no DONE, go to GAP. Otherwise go to RUN.
- State RUN:
  - VALVE[ZONE] = ~PAUSE, decoded combinationally from the registered state so PAUSE closes the valve in the same cycle.
  - Decrement REMAIN on TICK && !PAUSE. While PAUSE=1, REMAIN holds and the state holds.
  - When TICK && !PAUSE && REMAIN==1: REMAIN <= 0, DONE <= 1 for one cycle, last <= ZONE, go to GAP.
  - REQ deassertion during RUN is ignored; the run completes.
- State GAP:
  - VALVE=0, BUSY=1. Internal counter runs GAP cycles regardless of TICK and PAUSE, then goes to IDLE with BUSY=0.
- Latency: REQ sampled in IDLE at edge N gives LOAD after N+1 and RUN after N+2, with the valve open in that cycle.
- Arbitration:
  - Requests that arrive while BUSY are held until IDLE.
  - Simultaneous requests are resolved by pointer order only.
  - Every continuously requesting zone is served within NZONES runs.
- Invariants:
  - At most one VALVE bit is ever high.
  - VALVE=0 whenever state is not RUN.
  - REMAIN never wraps below 0.
  - All outputs except VALVE are registered.

Optional Feature:
- Macro: SCHED_FIXED_PRIO_EN.
- Defined: the grant is the lowest-index requesting zone, and the last-served pointer is unused.
- Undefined (default): round-robin as described in Behaviour.
- All other timing is identical in both builds.

Test Plan:
- Reset, then REQ=4'b0001, DUR0=3, TICK every 4th cycle -> LOAD at +1, RUN at +2 with VALVE=0001, REMAIN 3->2->1->0. DONE pulses on the third tick. VALVE=0 for 2 GAP cycles, then IDLE, BUSY=0.
- REQ=4'b1111 held, all DUR=1 -> zones served in order 0,1,2,3,0. Each run is separated by 2 VALVE=0 cycles, and exactly one VALVE bit is high at a time.
- During a run of zone 2 (REMAIN=5), PAUSE=1 for 10 cycles with ticks present -> VALVE=0 immediately, REMAIN stays 5. After PAUSE drops, counting resumes and DONE follows 5 ticks later.
- REQ=4'b0010 with DUR1=0 -> LOAD then GAP with no VALVE and no DONE. The next request from zone 1 or a higher zone is granted after the pointer.
- RESET asserted with REMAIN=7 in RUN -> next edge VALVE=0, BUSY=0, REMAIN=0, no DONE. A re-request restarts from zone 0.
- With SCHED_FIXED_PRIO_EN defined, REQ=4'b1001 held -> zone 0 is granted every run and zone 3 is never granted.
